// File: rtl/cam_pattern_gen.sv
// Camera test-pattern source: framed LANES-wide pixel words with a parallel sync-code channel.
// Outputs are registered, so they trail the internal line/frame state machine by one cycle.
module cam_pattern_gen #(
  parameter int LANES            = 4,
  parameter int PIX_BITS         = 8,
  parameter int COLS             = 64,
  parameter int ROWS             = 32,
  parameter int LINE_GAP         = 4,
  parameter int INTERFRAME_WORDS = 142
) (
  input  logic                      c,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      trig_mode,
  input  logic                      trigger,
  input  logic [1:0]                pattern,
  input  logic [PIX_BITS-1:0]       const_val,
  output logic [LANES*PIX_BITS-1:0] data,
  output logic [7:0]                sync,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               trig_missed
);

  localparam logic [7:0] SYNC_TR  = 8'h3A;
  localparam logic [7:0] SYNC_FS  = 8'hAA;
  localparam logic [7:0] SYNC_LS  = 8'h2A;
  localparam logic [7:0] SYNC_IMG = 8'h35;
  localparam logic [7:0] SYNC_LE  = 8'h0A;
  localparam logic [7:0] SYNC_FE  = 8'h4A;

  localparam logic [15:0] WORD_LAST = 16'(COLS / LANES - 1);
  localparam logic [15:0] ROW_LAST  = 16'(ROWS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(LINE_GAP - 1);
  localparam logic [15:0] IFG_LAST  = 16'(INTERFRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, SOL, PIX, EOL, GAP, IFG} state_t;

  state_t              state, state_n;
  logic [15:0]         cnt, cnt_n;
  logic [15:0]         row, row_n;
  logic                trig_q;
  logic                armed;
  logic                trig_rise;
  logic                start;
  logic                done_now;
  logic [1:0]          pat_q;
  logic [PIX_BITS-1:0] cval_q;
  logic [LANES*PIX_BITS-1:0] pix_word;
  logic [15:0]         col;
  logic [PIX_BITS-1:0] px;
  logic [7:0]          sync_code;

  // armed stays low for the first cycle after reset so a trigger held high through reset is not an edge
  assign trig_rise = trigger & ~trig_q & armed;
  assign start     = (state == IDLE) && enable && (!trig_mode || trig_rise);
  assign done_now  = (state == IFG) && (cnt == IFG_LAST);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      row    <= '0;
      trig_q <= 1'b0;
      armed  <= 1'b0;
      pat_q  <= '0;
      cval_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      row    <= row_n;
      trig_q <= trigger;
      armed  <= 1'b1;
      if (start) begin
        pat_q  <= pattern;
        cval_q <= const_val;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row;
    case (state)
      IDLE: if (start) begin
        state_n = SOL;
        cnt_n   = '0;
        row_n   = '0;
      end
      SOL: begin
        state_n = PIX;
        cnt_n   = '0;
      end
      PIX: if (cnt == WORD_LAST) begin
        state_n = EOL;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 16'd1;
      end
      EOL: if (row == ROW_LAST) begin
        state_n = IFG;
        cnt_n   = '0;
      end else if (LINE_GAP == 0) begin
        state_n = SOL;
        row_n   = row + 16'd1;
      end else begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: if (cnt == GAP_LAST) begin
        state_n = SOL;
        cnt_n   = '0;
        row_n   = row + 16'd1;
      end else begin
        cnt_n = cnt + 16'd1;
      end
      IFG: if (cnt == IFG_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pix_word = '0;
    col      = '0;
    px       = '0;
    for (int n = 0; n < LANES; n++) begin
      col = cnt * 16'(LANES) + 16'(n);
      case (pat_q)
        2'd0:    px = PIX_BITS'(row + col);
        2'd1:    px = (row[3] ^ col[3]) ? '1 : '0;
        2'd2:    px = PIX_BITS'(frame_cnt);
        default: px = cval_q;
      endcase
      pix_word[n*PIX_BITS +: PIX_BITS] = px;
    end
  end

  always_comb begin
    case (state)
      SOL:     sync_code = (row == 16'd0) ? SYNC_FS : SYNC_LS;
      PIX:     sync_code = SYNC_IMG;
      EOL:     sync_code = (row == ROW_LAST) ? SYNC_FE : SYNC_LE;
      default: sync_code = SYNC_TR;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      sync        <= SYNC_TR;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      trig_missed <= '0;
    end else begin
      data       <= (state == PIX) ? pix_word : '0;
      sync       <= sync_code;
      busy       <= (state != IDLE);
      frame_done <= done_now;
      if (done_now)
        frame_cnt <= frame_cnt + 16'd1;
      if (trig_rise && (state != IDLE) && (trig_missed != 16'hFFFF))
        trig_missed <= trig_missed + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen: default-parameter instance plus an 8-lane 10-bit checker instance.
module tb_cam_pattern_gen;

  localparam logic [7:0] TR  = 8'h3A;
  localparam logic [7:0] FS  = 8'hAA;
  localparam logic [7:0] LS  = 8'h2A;
  localparam logic [7:0] IMG = 8'h35;
  localparam logic [7:0] LE  = 8'h0A;
  localparam logic [7:0] FE  = 8'h4A;

  logic        c = 1'b0;
  logic        rst_n;
  logic        enable, trig_mode, trigger;
  logic [1:0]  pattern;
  logic [7:0]  const_val;
  logic [31:0] data;
  logic [7:0]  sync;
  logic        busy, frame_done;
  logic [15:0] frame_cnt, trig_missed;

  logic        en2;
  logic        tmode2 = 1'b0;
  logic        trig2 = 1'b0;
  logic [1:0]  pat2 = 2'd1;
  logic [9:0]  cval2 = 10'd0;
  logic [79:0] data2;
  logic [7:0]  sync2;
  logic        busy2, fd2;
  logic [15:0] fc2, tm2;

  int nvec = 0;
  int nerr = 0;
  int done_seen = 0;
  logic [31:0] img [32][16];

  always #5 c = ~c;

  cam_pattern_gen dut (
    .c(c), .rst_n(rst_n), .enable(enable), .trig_mode(trig_mode), .trigger(trigger),
    .pattern(pattern), .const_val(const_val), .data(data), .sync(sync), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .trig_missed(trig_missed)
  );

  cam_pattern_gen #(.LANES(8), .PIX_BITS(10), .COLS(64)) dut2 (
    .c(c), .rst_n(rst_n), .enable(en2), .trig_mode(tmode2), .trigger(trig2),
    .pattern(pat2), .const_val(cval2), .data(data2), .sync(sync2), .busy(busy2),
    .frame_done(fd2), .frame_cnt(fc2), .trig_missed(tm2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (sync !== FS && n < 10) begin
      step();
      n++;
    end
    chk("fs_wait", sync, FS);
  endtask

  // Walks one frame starting at the visible FS word and ending on the final IFG word.
  task automatic walk_frame(input int drop_row, input bit pulses, input int fc_exp);
    for (int r = 0; r < 32; r++) begin
      chk("sol", sync, (r == 0) ? FS : LS);
      chk("sol_data", data, 32'd0);
      chk("sol_busy", busy, 1);
      if (r == drop_row) begin
        pattern = 2'd3;
        enable  = 1'b0;
      end
      if (pulses && (r == 3 || r == 10 || r == 20)) trigger = 1'b1;
      step();
      trigger = 1'b0;
      for (int w = 0; w < 16; w++) begin
        chk("img", sync, IMG);
        img[r][w] = data;
        step();
      end
      chk("eol", sync, (r == 31) ? FE : LE);
      step();
      if (r != 31) begin
        for (int g = 0; g < 4; g++) begin
          chk("gap", sync, TR);
          step();
        end
      end
    end
    for (int i = 0; i < 142; i++) begin
      chk("ifg", sync, TR);
      chk("ifg_done", frame_done, (i == 141) ? 1 : 0);
      if (frame_done) done_seen++;
      if (i == 140) chk("fcnt_pre", frame_cnt, 32'(fc_exp - 1));
      if (i == 141) begin
        chk("fcnt_done", frame_cnt, 32'(fc_exp));
        chk("ifg_busy", busy, 1);
      end else begin
        step();
      end
    end
  endtask

  initial begin
    int n, nfs;
    logic [79:0] w0, w1;
    rst_n = 1'b1; enable = 1'b0; trig_mode = 1'b0; trigger = 1'b0;
    pattern = 2'd0; const_val = 8'h55; en2 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sync", sync, TR);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_miss", trig_missed, 0);
    chk("rst_sync2", sync2, TR);
    repeat (3) step();
    rst_n = 1'b1;

    // 8 lanes x 10 bits, checker pattern
    en2 = 1'b1;
    n = 0;
    while (sync2 !== FS && n < 10) begin step(); n++; end
    for (int r = 0; r <= 8; r++) begin
      chk("c2_sol", sync2, (r == 0) ? FS : LS);
      step();
      n = 0; w0 = '0; w1 = '0;
      while (sync2 === IMG && n < 20) begin
        if (n == 0) w0 = data2;
        if (n == 1) w1 = data2;
        n++;
        step();
      end
      chk("c2_words", n, 8);
      chk("c2_eol", sync2, LE);
      if (r == 0) begin
        chk("c2_r0c0", w0[9:0], 10'h000);
        chk("c2_r0c7", w0[79:70], 10'h000);
        chk("c2_r0c8", w1[9:0], 10'h3FF);
      end
      if (r == 8) begin
        chk("c2_r8c0", w0[9:0], 10'h3FF);
        chk("c2_r8c8", w1[9:0], 10'h000);
      end
      repeat (5) step();
    end
    en2 = 1'b0;

    // free-run ramp, two back-to-back frames, enable dropped in the second
    pattern = 2'd0; enable = 1'b1;
    wait_fs();
    walk_frame(-1, 1'b0, 1);
    w0 = 80'(img[5][3]);
    chk("ramp_r5w3l2", w0[23:16], 8'd19);
    w0 = 80'(img[0][0]);
    chk("ramp_r0w0l0", w0[7:0], 8'd0);
    w0 = 80'(img[31][15]);
    chk("ramp_r31w15l3", w0[31:24], 8'd94);
    step();
    chk("idle_tr", sync, TR);
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
    step();
    chk("next_fs", sync, FS);
    walk_frame(10, 1'b0, 2);
    w0 = 80'(img[10][2]);
    chk("held_r10w2l0", w0[7:0], 8'd18);
    w0 = 80'(img[20][0]);
    chk("held_r20w0l1", w0[15:8], 8'd21);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stop_tr", sync, TR);
      chk("stop_busy", busy, 0);
    end

    // reset in row 20 PIX, then triggered mode with trigger held through reset
    pattern = 2'd0; enable = 1'b1;
    wait_fs();
    repeat (20 * 22 + 5) step();
    chk("pre_rst_img", sync, IMG);
    rst_n = 1'b0; trig_mode = 1'b1; trigger = 1'b1;
    #1;
    chk("abort_sync", sync, TR);
    chk("abort_busy", busy, 0);
    chk("abort_data", data, 0);
    chk("abort_fcnt", frame_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    nfs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sync === FS) nfs++;
    end
    chk("held_trig_fs", nfs, 0);
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    chk("trig_k", sync, TR);
    step();
    chk("trig_k1_fs", sync, FS);
    trigger = 1'b0;
    walk_frame(-1, 1'b1, 1);
    chk("trig_missed", trig_missed, 3);
    nfs = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sync === FS) nfs++;
    end
    chk("one_frame", nfs, 0);

    // frame-count pattern over three free-run frames
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; trig_mode = 1'b0; pattern = 2'd2; enable = 1'b1;
    done_seen = 0;
    wait_fs();
    walk_frame(-1, 1'b0, 1);
    chk("fc_frame0", img[0][0], 32'h0000_0000);
    chk("fc_frame0_end", img[31][15], 32'h0000_0000);
    step(); step();
    walk_frame(-1, 1'b0, 2);
    chk("fc_frame1", img[7][9], 32'h0101_0101);
    step(); step();
    walk_frame(-1, 1'b0, 3);
    enable = 1'b0;
    chk("fc_frame2", img[31][0], 32'h0202_0202);
    chk("done_pulses", done_seen, 3);
    chk("fcnt_final", frame_cnt, 3);
    repeat (3) step();
    chk("end_tr", sync, TR);
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", nvec);
    $fatal(1, "timeout");
  end

endmodule
